// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the execute stage and datamem.
// Accepts one request at a time over a valid/ready handshake. Aligned accesses go out as a
// single native access. Misaligned half/word accesses are either split into byte accesses
// and reassembled (MISALIGN_SPLIT=1) or rejected with resp_err (MISALIGN_SPLIT=0).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_*               request channel (valid/ready, write, type, sign_ext, addr, wdata)
//   resp_*              one-cycle response pulse with read data and error flag
//   mem_*               datamem port set; mem_dout is a combinational read of mem_addr
module lsu_ctrl #(
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_type,
  input  logic        req_sign_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_en,
  output logic [1:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {StIdle, StAccess, StSplit, StResp, StErr} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  type_q, type_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        misaligned;
  logic [1:0]  last_cnt;
  logic [31:0] split_result;

  always_comb begin
    misaligned = ((req_type == 2'b01) && req_addr[0]) ||
                 ((req_type == 2'b10) && (req_addr[1:0] != 2'b00));
    last_cnt   = (type_q == 2'b01) ? 2'd1 : 2'd3;
  end

  // Merge the current byte into the assembly register; on the final byte of a signed split
  // half, replicate the freshly written bit 15 into the upper half.
  always_comb begin
    split_result = result_q;
    unique case (cnt_q)
      2'd0: split_result[7:0]   = mem_dout[7:0];
      2'd1: split_result[15:8]  = mem_dout[7:0];
      2'd2: split_result[23:16] = mem_dout[7:0];
      2'd3: split_result[31:24] = mem_dout[7:0];
    endcase
    if ((type_q == 2'b01) && sext_q && (cnt_q == last_cnt)) begin
      split_result[31:16] = {16{split_result[15]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    type_d   = type_q;
    sext_d   = sext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          type_d   = req_type;
          sext_d   = req_sign_ext;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = 2'd0;
          result_d = '0;
          if (req_type == 2'b11)  state_d = StErr;
          else if (misaligned)    state_d = MISALIGN_SPLIT ? StSplit : StErr;
          else                    state_d = StAccess;
        end
      end
      StAccess: begin
        if (!write_q) result_d = mem_dout;
        state_d = StResp;
      end
      StSplit: begin
        if (!write_q) result_d = split_result;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_cnt) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      type_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      type_q   <= type_d;
      sext_q   <= sext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs depend only on registered state; writes are additionally gated by rst so an
  // abandoned access never writes in the reset cycle.
  always_comb begin
    req_ready    = (state_q == StIdle);
    resp_valid   = (state_q == StResp) || (state_q == StErr);
    resp_err     = (state_q == StErr);
    resp_rdata   = ((state_q == StResp) && !write_q) ? result_q : '0;
    mem_write_en = 1'b0;
    mem_type     = 2'b10;
    mem_addr     = '0;
    mem_din      = '0;
    mem_sign_ext = 1'b0;
    case (state_q)
      StAccess: begin
        mem_write_en = write_q & ~rst;
        mem_type     = type_q;
        mem_addr     = addr_q;
        mem_din      = wdata_q;
        mem_sign_ext = sext_q;
      end
      StSplit: begin
        mem_write_en = write_q & ~rst;
        mem_type     = 2'b00;
        mem_addr     = addr_q + {30'b0, cnt_q};
        mem_din      = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a table of requests with expected responses, a
// scoreboard queue popped on each resp_valid, and hand-written back-to-back and
// reset-mid-split sequences. Instance a splits misaligned accesses, instance b rejects them.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        a_v, b_v;
  logic        req_write;
  logic [1:0]  req_type;
  logic        req_sign_ext;
  logic [31:0] req_addr, req_wdata;

  logic        a_ready, a_rv, a_err, a_we, a_sext;
  logic [31:0] a_rd, a_addr, a_din, a_dout;
  logic [1:0]  a_type;
  logic        b_ready, b_rv, b_err, b_we, b_sext;
  logic [31:0] b_rd, b_addr, b_din, b_dout;
  logic [1:0]  b_type;

  lsu_ctrl #(.MISALIGN_SPLIT(1'b1)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_v), .req_ready(a_ready), .req_write(req_write),
    .req_type(req_type), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err),
    .mem_write_en(a_we), .mem_type(a_type), .mem_addr(a_addr), .mem_din(a_din),
    .mem_sign_ext(a_sext), .mem_dout(a_dout)
  );

  lsu_ctrl #(.MISALIGN_SPLIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_v), .req_ready(b_ready), .req_write(req_write),
    .req_type(req_type), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(b_rv), .resp_rdata(b_rd), .resp_err(b_err),
    .mem_write_en(b_we), .mem_type(b_type), .mem_addr(b_addr), .mem_din(b_din),
    .mem_sign_ext(b_sext), .mem_dout(b_dout)
  );

  // datamem model: 256 bytes, little-endian, addresses taken modulo 256.
  logic [7:0] mem [256];
  int wr_a = 0, wr_b = 0;

  function automatic logic [31:0] rd(input logic [1:0] t, input logic s,
                                     input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
    case (t)
      2'b00:   return s ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   return s ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  assign a_dout = rd(a_type, a_sext, mem[a_addr[7:0]], mem[a_addr[7:0] + 8'd1],
                     mem[a_addr[7:0] + 8'd2], mem[a_addr[7:0] + 8'd3]);
  assign b_dout = rd(b_type, b_sext, mem[b_addr[7:0]], mem[b_addr[7:0] + 8'd1],
                     mem[b_addr[7:0] + 8'd2], mem[b_addr[7:0] + 8'd3]);

  logic        w_en;
  logic [1:0]  w_type;
  logic [7:0]  w_a;
  logic [31:0] w_d;
  assign w_en   = a_we | b_we;
  assign w_type = a_we ? a_type : b_type;
  assign w_a    = a_we ? a_addr[7:0] : b_addr[7:0];
  assign w_d    = a_we ? a_din : b_din;

  always @(posedge clk) begin
    if (w_en) begin
      mem[w_a] <= w_d[7:0];
      if (w_type != 2'b00) mem[w_a + 8'd1] <= w_d[15:8];
      if (w_type == 2'b10) begin
        mem[w_a + 8'd2] <= w_d[23:16];
        mem[w_a + 8'd3] <= w_d[31:24];
      end
    end
    if (a_we) wr_a <= wr_a + 1;
    if (b_we) wr_b <= wr_b + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  task automatic pop(input int d, input logic [31:0] r, input logic e);
    exp_t x;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_resp: dut %0d got resp_valid=1, expected 0 (cycle %0d)", d, cyc);
      return;
    end
    x = sb_q.pop_front();
    chk("resp_dut", d, x.dut);
    chk("resp_rdata", r, x.rdata);
    chk("resp_err", {31'b0, e}, {31'b0, x.err});
    chk("resp_cycle", cyc, x.at);
  endtask

  always @(negedge clk) begin
    if (a_rv) pop(0, a_rd, a_err);
    if (b_rv) pop(1, b_rd, b_err);
  end

  typedef struct {
    int          dut;
    logic        wr;
    logic [1:0]  typ;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          nwr;
  } vec_t;

  function automatic vec_t mk(input int dut, input logic wr, input logic [1:0] typ,
                              input logic sx, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input logic exp_err, input int lat, input int nwr);
    vec_t v;
    v.dut = dut; v.wr = wr; v.typ = typ; v.sx = sx; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.lat = lat; v.nwr = nwr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_write    = v.wr;
    req_type     = v.typ;
    req_sign_ext = v.sx;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  // Called at a negedge; returns at a negedge with the acceptance cycle in t (-1 on timeout).
  task automatic wait_ready(input int dut, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      if ((dut == 0 && a_ready) || (dut == 1 && b_ready)) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_timeout: dut %0d ready stayed 0, expected 1", dut);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int t, w0;
    exp_t x;
    w0 = (v.dut == 0) ? wr_a : wr_b;
    drive(v);
    if (v.dut == 0) a_v = 1'b1; else b_v = 1'b1;
    wait_ready(v.dut, t);
    if (t >= 0) begin
      x.dut = v.dut; x.rdata = v.exp_rd; x.err = v.exp_err; x.at = t + v.lat;
      sb_q.push_back(x);
    end
    @(negedge clk);
    a_v = 1'b0;
    b_v = 1'b0;
    drain();
    chk("write_count", ((v.dut == 0) ? wr_a : wr_b) - w0, v.nwr);
  endtask

  vec_t vecs[$];

  initial begin
    int t, w0;
    exp_t x;
    vec_t v;
    rst = 1'b1; a_v = 1'b0; b_v = 1'b0;
    req_write = 1'b0; req_type = 2'b00; req_sign_ext = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, a_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, a_rv}, 32'd0);
    chk("rst_resp_rdata", a_rd, 32'd0);
    chk("rst_resp_err", {31'b0, a_err}, 32'd0);
    chk("rst_mem_write_en", {31'b0, a_we}, 32'd0);
    chk("rst_mem_type", {30'b0, a_type}, 32'd2);
    chk("rst_mem_addr", a_addr, 32'd0);
    chk("rst_mem_din", a_din, 32'd0);
    chk("rst_mem_sign_ext", {31'b0, a_sext}, 32'd0);
    chk("rst_b_req_ready", {31'b0, b_ready}, 32'd1);

    //               dut wr typ   sx  addr          wdata         exp_rd        err lat nwr
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h20,       32'h80,       32'h0,        0, 2, 1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h33,       32'h01,       32'h0,        0, 2, 1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h34,       32'hF0,       32'h0,        0, 2, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h20,       32'h0,        32'hFFFFFF80, 0, 2, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h20,       32'h0,        32'h00000080, 0, 2, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h41,       32'h11223344, 32'h0,        0, 5, 4));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h41,       32'h0,        32'h11223344, 0, 5, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h44,       32'h0,        32'h00000011, 0, 2, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h33,       32'h0,        32'hFFFFF001, 0, 3, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h33,       32'h0,        32'h0000F001, 0, 3, 0));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h10,       32'h0,        32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h10,       32'h55555555, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h50,       32'hABCD,     32'h0,        0, 2, 1));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h50,       32'h0,        32'hFFFFABCD, 0, 2, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h0,        0, 5, 4));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 0, 5, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h00,       32'h0,        32'hFFFFFFF0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h61,       32'h1234,     32'h0,        0, 3, 2));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h61,       32'h0,        32'h00001234, 0, 3, 0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h33,       32'h0,        32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h41,       32'h99999999, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h41,       32'h0,        32'h11223344, 0, 5, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: valid held high, second request waits until after the RESP cycle.
    drive(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0));
    a_v = 1'b1;
    wait_ready(0, t);
    if (t >= 0) begin
      x.dut = 0; x.rdata = 32'hDEADBEEF; x.err = 1'b0; x.at = t + 2;
      sb_q.push_back(x);
      @(negedge clk);
      chk("b2b_ready_access", {31'b0, a_ready}, 32'd0);
      drive(mk(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0));
      x.dut = 0; x.rdata = 32'h0; x.err = 1'b1; x.at = t + 4;
      sb_q.push_back(x);
      @(negedge clk);
      chk("b2b_ready_resp", {31'b0, a_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_idle", {31'b0, a_ready}, 32'd1);
      @(negedge clk);
    end
    a_v = 1'b0;
    drain();

    // Reset during the third split cycle of a misaligned word store.
    w0 = wr_a;
    drive(mk(0, 1, 2'b10, 0, 32'h41, 32'hA1B2C3D4, 32'h0, 0, 0, 0));
    a_v = 1'b1;
    wait_ready(0, t);
    @(posedge clk); #1;
    a_v = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_split_write_en", {31'b0, a_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_split_ready", {31'b0, a_ready}, 32'd1);
    chk("rst_split_resp_valid", {31'b0, a_rv}, 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_split_writes", wr_a - w0, 32'd2);
    chk("rst_split_mem41", {24'h0, mem[8'h41]}, 32'hD4);
    chk("rst_split_mem42", {24'h0, mem[8'h42]}, 32'hC3);
    chk("rst_split_mem43", {24'h0, mem[8'h43]}, 32'h22);
    chk("rst_split_mem44", {24'h0, mem[8'h44]}, 32'h11);
    v = mk(0, 0, 2'b10, 0, 32'h41, 32'h0, 32'h1122C3D4, 0, 5, 0);
    run_vec(v);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the execute stage and `datamem`.
- Accepts one load/store request at a time over a valid/ready handshake and drives the `datamem` port set (`write_en`, `type_control`, `addr`, `din`, `sign_ext`, `dout`).
- Aligned accesses are issued as a single native access.
- Misaligned halfword/word accesses are split into sequential byte accesses; the result is reassembled and sign-extended.
- Returns a one-cycle response pulse.

Parameters:
- MISALIGN_SPLIT, 1: 1 = split misaligned accesses into byte accesses; 0 = reject them with `resp_err`, no memory access.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_type  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign_ext  input  1  sign-extend load result (byte/half only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid; illegal type or rejected misaligned access.
- mem_write_en  output  1  to datamem `write_en`.
- mem_type  output  2  to datamem `type_control`.
- mem_addr  output  32  to datamem `addr`.
- mem_din  output  32  to datamem `din`.
- mem_sign_ext  output  1  to datamem `sign_ext`.
- mem_dout  input  32  from datamem `dout`; combinational read of `mem_addr`.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset state: IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
  - mem_write_en=0, mem_type=10, mem_addr=0, mem_din=0, mem_sign_ext=0.
- Memory outputs are combinational from registered state. They hold the reset values in IDLE, RESP and ERR.
- mem_write_en is gated by !rst, so no write ever occurs in a cycle with rst high.
- Alignment rule:
  - byte is always aligned;
  - half is aligned iff addr[0]=0;
  - word is aligned iff addr[1:0]=00.
- States: IDLE, ACCESS, SPLIT, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, type, sign_ext, addr, wdata; clear byte counter cnt (2 bits) and the assembly register.
  - Next state: type 11 -> ERR; misaligned with MISALIGN_SPLIT=0 -> ERR; misaligned with MISALIGN_SPLIT=1 -> SPLIT; otherwise -> ACCESS.
- ACCESS (1 cycle):
  - Drive mem_type=latched type, mem_addr=latched addr, mem_din=latched wdata, mem_write_en=latched write, mem_sign_ext=latched sign_ext.
  - Capture mem_dout into the result register on loads.
  - Next state: RESP.
- SPLIT (N cycles; N=2 for half, 4 for word):
  - Drive mem_type=00, mem_addr=latched addr+cnt (32-bit modulo wrap), mem_din={24'b0, wdata byte cnt}, mem_sign_ext=0, mem_write_en=latched write.
  - On loads, write mem_dout[7:0] into result byte cnt.
  - cnt increments each cycle; on cnt==N-1, go to RESP.
- Split loads: for half with sign_ext=1, result[31:16] = replicated result[15]; otherwise zero.
- RESP: resp_valid=1, resp_err=0, resp_rdata=result (0 for stores) for exactly one cycle, then IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, no memory access, then IDLE.
- Outside RESP/ERR: resp_valid=0, resp_err=0, and resp_rdata is held at 0.
- Latency, with acceptance at cycle T:
  - aligned: resp_valid at T+2;
  - misaligned half: T+3;
  - misaligned word: T+5;
  - error: T+1.
- Throughput: a new request is accepted no earlier than the cycle after the RESP/ERR cycle. req_valid while req_ready=0 is ignored and must be held by the producer.
- Reset mid-SPLIT or mid-ACCESS:
  - the in-flight access is abandoned, with no write in the reset cycle;
  - no resp_valid pulse is issued for it;
  - state returns to IDLE on the next edge.
- Bytes already written by an abandoned split store remain written; partial stores are not rolled back.

Test Plan:
- Aligned word store 0xDEADBEEF @0x10, then word load @0x10 -> one ACCESS each; load resp_rdata=0xDEADBEEF at T+2, resp_err=0.
- Byte load @0x20 holding 0x80: sign_ext=1 -> 0xFFFFFF80; sign_ext=0 -> 0x00000080.
- Misaligned word store 0x11223344 @0x41 -> four byte writes (0x44 @0x41, 0x33 @0x42, 0x22 @0x43, 0x11 @0x44); word load @0x41 returns 0x11223344 at T+5.
- Misaligned half load @0x33 with bytes 0x34=0xF0, 0x33=0x01, sign_ext=1 -> 0xFFFFF001 at T+3. With MISALIGN_SPLIT=0 -> resp_err=1, rdata=0 at T+1, mem_write_en never high.
- req_type=11 -> resp_valid+resp_err at T+1, no memory activity. Back-to-back req_valid held high -> second request accepted only after the RESP/ERR cycle.
- rst asserted during the 3rd SPLIT cycle of a word store @0x41 -> no write in that cycle, no resp_valid, req_ready=1 on the next cycle; bytes @0x41 and @0x42 hold the new data, @0x43 and @0x44 are unchanged.
